// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream
//   N-to-1 registered stream multiplexer. Each input lane has its own
//   valid/ready handshake; one lane per cycle is granted, either the lane
//   named by sel (direct mode) or the next valid lane after the last
//   round-robin winner (round-robin mode). The granted lane's data is
//   captured into a one-entry output stage with its own valid/ready handshake.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   en         acceptance enable; 0 blocks new grants, output still drains
//   mode       0 = direct select, 1 = round-robin
//   sel        lane index used in direct mode (values >= NUM_IN grant nothing)
//   in         packed lanes, lane i at in[i*DW_DATA +: DW_DATA], signed
//   in_valid   per-lane valid
//   in_ready   per-lane ready, combinational, one-hot or zero
//   out        registered data of the granted lane, signed
//   out_sel    lane index that produced out
//   out_valid  output stage holds a transfer
//   out_ready  downstream accepts out

module mux_nto1_stream #(
    parameter int unsigned DW_DATA = 128,
    parameter int unsigned NUM_IN  = 8,
    parameter int unsigned SEL_W   = $clog2(NUM_IN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_IN*DW_DATA-1:0] in,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_IN-1:0]         in_ready,
    output logic signed [DW_DATA-1:0] out,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic signed [DW_DATA-1:0] out_q, out_d;
    logic [SEL_W-1:0]          out_sel_q, out_sel_d;
    logic                      out_valid_q, out_valid_d;
    logic [SEL_W-1:0]          rr_ptr_q, rr_ptr_d;

    logic                      slot_free;
    logic                      grant_exists;
    logic [SEL_W-1:0]          grant_idx;
    logic                      accept;
    logic signed [DW_DATA-1:0] lane_data;

    // Round-robin search split in two halves: first valid lane above rr_ptr,
    // otherwise first valid lane from 0. Equivalent to a wrapping scan
    // starting at rr_ptr+1 without modulo arithmetic.
    logic             hi_found, lo_found;
    logic [SEL_W-1:0] hi_idx, lo_idx;

    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (!hi_found && in_valid[i] && (SEL_W'(i) > rr_ptr_q)) begin
                hi_found = 1'b1;
                hi_idx   = SEL_W'(i);
            end
            if (!lo_found && in_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = SEL_W'(i);
            end
        end
    end

    always_comb begin
        grant_exists = 1'b0;
        grant_idx    = '0;
        if (mode) begin
            grant_exists = hi_found || lo_found;
            grant_idx    = hi_found ? hi_idx : lo_idx;
        end else begin
            // Compare against each real lane so sel >= NUM_IN matches nothing.
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if ((sel == SEL_W'(i)) && in_valid[i]) begin
                    grant_exists = 1'b1;
                    grant_idx    = SEL_W'(i);
                end
            end
        end
    end

    // rst gates in_ready so it drops the moment reset is asserted, even
    // though the cleared output stage would otherwise look free.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            in_ready[i] = !rst && en && slot_free && grant_exists &&
                          (grant_idx == SEL_W'(i));
        end
    end

    assign accept = |(in_valid & in_ready);

    always_comb begin
        lane_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                lane_data = $signed(in[i*DW_DATA +: DW_DATA]);
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            out_d       = lane_data;
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                rr_ptr_d = grant_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SEL_W'(NUM_IN - 1);
        end else begin
            out_q       <= out_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out       = out_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
